// File: rtl/match_seq_ctrl.sv
// Sequencer that feeds test_timer compare values from a programmable table and restarts the timer per entry.
// Optional sticky completion interrupt (IRQ/IRQ_CLR) is built when MATCH_SEQ_IRQ_EN is defined.
module match_seq_ctrl #(
  parameter int MW    = 5,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CFG_WE,
  input  logic [AW-1:0]    CFG_ADDR,
  input  logic [MW-1:0]    CFG_DATA,
  input  logic [CNT_W-1:0] LOOP_CNT,
  input  logic             START,
  input  logic             STOP,
  input  logic             MATCH_OUT,
  output logic [MW-1:0]    MATCH_IN,
  output logic             TIMER_RST,
  output logic [AW-1:0]    SEQ_IDX,
  output logic             WAVE,
  output logic             BUSY,
  output logic             DONE
`ifdef MATCH_SEQ_IRQ_EN
  ,
  input  logic             IRQ_CLR,
  output logic             IRQ
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state_q, state_d;
  logic [MW-1:0]      tbl_q [DEPTH];
  logic [MW-1:0]      match_in_q, match_in_d;
  logic               timer_rst_q, timer_rst_d;
  logic [AW-1:0]      seq_idx_q, seq_idx_d;
  logic               wave_q, wave_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   loop_q, loop_d;
  logic [CNT_W-1:0]   pass_inc;
  logic               wrap;
`ifdef MATCH_SEQ_IRQ_EN
  logic               irq_q, irq_d;
`endif

  // Table is plain storage: no reset, writable in any state.
  always_ff @(posedge CLK) begin
    if (CFG_WE) tbl_q[CFG_ADDR] <= CFG_DATA;
  end

  always_comb begin
    state_d    = state_q;
    match_in_d = match_in_q;
    seq_idx_d  = seq_idx_q;
    wave_d     = wave_q;
    pass_d     = pass_q;
    loop_d     = loop_q;
    done_d     = 1'b0;
    pass_inc   = (&pass_q) ? pass_q : pass_q + CNT_W'(1);
    wrap       = &seq_idx_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = LOAD;
          seq_idx_d = '0;
          pass_d    = '0;
          loop_d    = LOOP_CNT;
          wave_d    = 1'b0;
        end
      end
      LOAD: begin
        if (STOP) begin
          state_d = IDLE;
        end else begin
          match_in_d = tbl_q[seq_idx_q];
          state_d    = RUN;
        end
      end
      RUN: begin
        // STOP outranks a coincident match: nothing advances.
        if (STOP) begin
          state_d = IDLE;
        end else if (MATCH_OUT) begin
          wave_d    = ~wave_q;
          seq_idx_d = seq_idx_q + AW'(1);
          if (wrap) pass_d = pass_inc;
          if (wrap && (loop_q != '0) && (pass_inc == loop_q)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    timer_rst_d = (state_d != RUN);
    busy_d      = (state_d != IDLE);
  end

`ifdef MATCH_SEQ_IRQ_EN
  // Set (one cycle after DONE) beats a coincident clear.
  always_comb begin
    irq_d = irq_q;
    if (done_q)       irq_d = 1'b1;
    else if (IRQ_CLR) irq_d = 1'b0;
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      match_in_q  <= '0;
      timer_rst_q <= 1'b1;
      seq_idx_q   <= '0;
      wave_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= '0;
      loop_q      <= '0;
`ifdef MATCH_SEQ_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      match_in_q  <= match_in_d;
      timer_rst_q <= timer_rst_d;
      seq_idx_q   <= seq_idx_d;
      wave_q      <= wave_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      loop_q      <= loop_d;
`ifdef MATCH_SEQ_IRQ_EN
      irq_q       <= irq_d;
`endif
    end
  end

  assign MATCH_IN  = match_in_q;
  assign TIMER_RST = timer_rst_q;
  assign SEQ_IDX   = seq_idx_q;
  assign WAVE      = wave_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
`ifdef MATCH_SEQ_IRQ_EN
  assign IRQ       = irq_q;
`endif

endmodule

// File: tb/tb_match_seq_ctrl.sv
// Self-checking bench for match_seq_ctrl: randomized sequences against a transaction-level table/pass model.
// IRQ checks are compiled when MATCH_SEQ_IRQ_EN is defined.
module tb_match_seq_ctrl;
  localparam int MW    = 5;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CNT_W = 8;

  logic             CLK;
  logic             RST;
  logic             CFG_WE;
  logic [AW-1:0]    CFG_ADDR;
  logic [MW-1:0]    CFG_DATA;
  logic [CNT_W-1:0] LOOP_CNT;
  logic             START, STOP, MATCH_OUT;
  logic [MW-1:0]    MATCH_IN;
  logic             TIMER_RST;
  logic [AW-1:0]    SEQ_IDX;
  logic             WAVE, BUSY, DONE;
`ifdef MATCH_SEQ_IRQ_EN
  logic             IRQ_CLR, IRQ;
`endif

  match_seq_ctrl #(.MW(MW), .DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .LOOP_CNT(LOOP_CNT), .START(START), .STOP(STOP), .MATCH_OUT(MATCH_OUT),
    .MATCH_IN(MATCH_IN), .TIMER_RST(TIMER_RST), .SEQ_IDX(SEQ_IDX), .WAVE(WAVE),
    .BUSY(BUSY), .DONE(DONE)
`ifdef MATCH_SEQ_IRQ_EN
    , .IRQ_CLR(IRQ_CLR), .IRQ(IRQ)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: table image, expected index/wave/pass, programmed loop count.
  logic [MW-1:0] m_tbl [DEPTH];
  int            m_idx, m_pass, m_loop;
  logic          m_wave;
  int            done_cnt, toggle_cnt;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input int a, input int d);
    CFG_WE = 1'b1; CFG_ADDR = AW'(a); CFG_DATA = MW'(d);
    tick;
    CFG_WE = 1'b0;
    m_tbl[a] = MW'(d);
  endtask

  task automatic start_seq(input int loopc);
    LOOP_CNT = CNT_W'(loopc);
    START = 1'b1;
    tick;
    START = 1'b0;
    m_idx = 0; m_pass = 0; m_loop = loopc; m_wave = 1'b0;
    n_cmp++;
    if ({BUSY, TIMER_RST, WAVE, SEQ_IDX} !== {1'b1, 1'b1, 1'b0, AW'(0)}) begin
      n_err++;
      $display("FAIL start_load: got busy/trst/wave/idx=%b expected %b", {BUSY, TIMER_RST, WAVE, SEQ_IDX}, {1'b1, 1'b1, 1'b0, AW'(0)});
    end
    tick;
    n_cmp++;
    if ({TIMER_RST, MATCH_IN} !== {1'b0, m_tbl[0]}) begin
      n_err++;
      $display("FAIL start_run: got trst=%b match_in=%0d expected trst=0 match_in=%0d", TIMER_RST, MATCH_IN, m_tbl[0]);
    end
  endtask

  // Dwell gap cycles in RUN, deliver one match, check the model's view; glitch pulses MATCH_OUT in the following non-RUN cycle.
  task automatic do_match(input int gap, input bit glitch);
    logic exp_done;
    logic prev_wave;
    repeat (gap) tick;
    prev_wave = WAVE;
    MATCH_OUT = 1'b1;
    tick;
    MATCH_OUT = 1'b0;
    m_wave = ~m_wave;
    m_idx  = (m_idx + 1) % DEPTH;
    if (m_idx == 0 && m_pass < 255) m_pass++;
    exp_done = (m_loop != 0) && (m_idx == 0) && (m_pass == m_loop);
    if (WAVE !== prev_wave) toggle_cnt++;
    if (DONE === 1'b1) done_cnt++;
    n_cmp++;
    if ({WAVE, SEQ_IDX, DONE, BUSY, TIMER_RST} !== {m_wave, AW'(m_idx), exp_done, ~exp_done, 1'b1}) begin
      n_err++;
      $display("FAIL after_match: got wave/idx/done/busy/trst=%b expected %b", {WAVE, SEQ_IDX, DONE, BUSY, TIMER_RST}, {m_wave, AW'(m_idx), exp_done, ~exp_done, 1'b1});
    end
    MATCH_OUT = glitch;
    tick;
    MATCH_OUT = 1'b0;
    n_cmp++;
    if (!exp_done) begin
      if ({TIMER_RST, MATCH_IN, DONE, WAVE, SEQ_IDX} !== {1'b0, m_tbl[m_idx], 1'b0, m_wave, AW'(m_idx)}) begin
        n_err++;
        $display("FAIL reload: got trst=%b match_in=%0d done=%b wave=%b idx=%0d expected trst=0 match_in=%0d done=0 wave=%b idx=%0d",
                 TIMER_RST, MATCH_IN, DONE, WAVE, SEQ_IDX, m_tbl[m_idx], m_wave, m_idx);
      end
    end else begin
      if ({DONE, BUSY, TIMER_RST, WAVE} !== {1'b0, 1'b0, 1'b1, m_wave}) begin
        n_err++;
        $display("FAIL after_done: got done/busy/trst/wave=%b expected %b", {DONE, BUSY, TIMER_RST, WAVE}, {1'b0, 1'b0, 1'b1, m_wave});
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_DATA = '0; LOOP_CNT = '0;
    START = 1'b0; STOP = 1'b0; MATCH_OUT = 1'b0;
`ifdef MATCH_SEQ_IRQ_EN
    IRQ_CLR = 1'b0;
`endif
    #25;
    n_cmp++;
    if ({MATCH_IN, TIMER_RST, BUSY, WAVE, DONE, SEQ_IDX} !== {MW'(0), 1'b1, 1'b0, 1'b0, 1'b0, AW'(0)}) begin
      n_err++;
      $display("FAIL reset: got match_in=%0d trst=%b busy=%b wave=%b done=%b idx=%0d", MATCH_IN, TIMER_RST, BUSY, WAVE, DONE, SEQ_IDX);
    end
`ifdef MATCH_SEQ_IRQ_EN
    n_cmp++;
    if (IRQ !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq: got %b expected 0", IRQ);
    end
`endif
    @(negedge CLK);
    RST = 1'b1;
    tick;
  endtask

  task automatic test_normal;
    int vals [4] = '{3, 5, 2, 4};
    for (int i = 0; i < DEPTH; i++) cfg_write(i, vals[i]);
    done_cnt = 0; toggle_cnt = 0;
    start_seq(2);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (MATCH_IN !== MW'(vals[k % 4])) begin
        n_err++;
        $display("FAIL normal_seq[%0d]: got %0d expected %0d", k, MATCH_IN, vals[k % 4]);
      end
      do_match(k % 3, 1'b0);
    end
    n_cmp++;
    if (toggle_cnt != 8 || done_cnt != 1 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL normal_summary: got toggles=%0d dones=%0d busy=%b expected 8 1 0", toggle_cnt, done_cnt, BUSY);
    end
  endtask

  task automatic test_continuous;
    done_cnt = 0;
    start_seq(0);
    for (int k = 0; k < 20; k++) do_match($urandom_range(0, 2), 1'b0);
    n_cmp++;
    if ({BUSY, SEQ_IDX, WAVE} !== {1'b1, AW'(0), 1'b0} || done_cnt != 0) begin
      n_err++;
      $display("FAIL cont_20: got busy=%b idx=%0d wave=%b dones=%0d expected 1 0 0 0", BUSY, SEQ_IDX, WAVE, done_cnt);
    end
    STOP = 1'b1;
    tick;
    STOP = 1'b0;
    n_cmp++;
    if ({BUSY, DONE, TIMER_RST} !== 3'b001) begin
      n_err++;
      $display("FAIL cont_stop: got busy/done/trst=%b expected 001", {BUSY, DONE, TIMER_RST});
    end
    tick;
    n_cmp++;
    if ({BUSY, DONE} !== 2'b00) begin
      n_err++;
      $display("FAIL cont_stop_hold: got busy/done=%b expected 00", {BUSY, DONE});
    end
  endtask

  task automatic test_collision;
    start_seq(0);
    do_match(1, 1'b0);
    STOP = 1'b1; MATCH_OUT = 1'b1;
    tick;
    STOP = 1'b0; MATCH_OUT = 1'b0;
    n_cmp++;
    if ({SEQ_IDX, WAVE, BUSY, DONE, TIMER_RST} !== {AW'(1), 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL collision: got idx/wave/busy/done/trst=%b expected %b", {SEQ_IDX, WAVE, BUSY, DONE, TIMER_RST}, {AW'(1), 1'b1, 1'b0, 1'b0, 1'b1});
    end
    MATCH_OUT = 1'b1;
    tick;
    MATCH_OUT = 1'b0;
    tick;
    n_cmp++;
    if ({SEQ_IDX, WAVE, BUSY} !== {AW'(1), 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL idle_match_ignored: got idx/wave/busy=%b expected %b", {SEQ_IDX, WAVE, BUSY}, {AW'(1), 1'b1, 1'b0});
    end
    LOOP_CNT = '0; START = 1'b1; STOP = 1'b1;
    tick;
    START = 1'b0; STOP = 1'b0;
    n_cmp++;
    if ({BUSY, WAVE, SEQ_IDX} !== {1'b1, 1'b0, AW'(0)}) begin
      n_err++;
      $display("FAIL start_beats_stop: got busy/wave/idx=%b expected %b", {BUSY, WAVE, SEQ_IDX}, {1'b1, 1'b0, AW'(0)});
    end
    tick;
    STOP = 1'b1;
    tick;
    STOP = 1'b0;
  endtask

  task automatic test_live_reconfig;
    int vals [4] = '{3, 5, 2, 4};
    for (int i = 0; i < DEPTH; i++) cfg_write(i, vals[i]);
    start_seq(1);
    cfg_write(2, 7);
    do_match(0, 1'b0);
    do_match(0, 1'b0);
    n_cmp++;
    if (MATCH_IN !== MW'(7)) begin
      n_err++;
      $display("FAIL live_reconfig: got %0d expected 7", MATCH_IN);
    end
    do_match(0, 1'b0);
    do_match(0, 1'b0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      int lc;
      for (int i = 0; i < DEPTH; i++) cfg_write(i, $urandom_range(0, 31));
      lc = $urandom_range(1, 3);
      done_cnt = 0;
      start_seq(lc);
      for (int k = 0; k < lc * DEPTH; k++) begin
        if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 31));
        do_match($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      n_cmp++;
      if (done_cnt != 1 || BUSY !== 1'b0) begin
        n_err++;
        $display("FAIL random_run[%0d]: got dones=%0d busy=%b expected 1 0", it, done_cnt, BUSY);
      end
    end
  endtask

  task automatic test_async_reset;
    start_seq(0);
    do_match(0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({MATCH_IN, TIMER_RST, BUSY, WAVE, DONE, SEQ_IDX} !== {MW'(0), 1'b1, 1'b0, 1'b0, 1'b0, AW'(0)}) begin
      n_err++;
      $display("FAIL async_reset: got match_in=%0d trst=%b busy=%b wave=%b done=%b idx=%0d", MATCH_IN, TIMER_RST, BUSY, WAVE, DONE, SEQ_IDX);
    end
    @(negedge CLK);
    RST = 1'b1;
    tick;
  endtask

`ifdef MATCH_SEQ_IRQ_EN
  task automatic test_irq;
    start_seq(1);
    for (int k = 0; k < 3; k++) do_match(0, 1'b0);
    MATCH_OUT = 1'b1;
    tick;
    MATCH_OUT = 1'b0;
    n_cmp++;
    if ({DONE, IRQ} !== 2'b10) begin
      n_err++;
      $display("FAIL irq_pre: got done/irq=%b expected 10", {DONE, IRQ});
    end
    IRQ_CLR = 1'b1;
    tick;
    IRQ_CLR = 1'b0;
    n_cmp++;
    if (IRQ !== 1'b1) begin
      n_err++;
      $display("FAIL irq_set_beats_clr: got %b expected 1", IRQ);
    end
    repeat (3) tick;
    n_cmp++;
    if (IRQ !== 1'b1) begin
      n_err++;
      $display("FAIL irq_sticky: got %b expected 1", IRQ);
    end
    IRQ_CLR = 1'b1;
    tick;
    IRQ_CLR = 1'b0;
    n_cmp++;
    if (IRQ !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear: got %b expected 0", IRQ);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_normal;
    test_continuous;
    test_collision;
    test_live_reconfig;
    test_random;
    test_async_reset;
`ifdef MATCH_SEQ_IRQ_EN
    test_irq;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
